lsu: RTL

Load/store unit for the single-issue RV32I core. Sits directly downstream of the instruction decoder and ALU: it consumes the decoder's `MemOp`, `MemWr` and `MemtoReg` controls together with the ALU address and the rs2 data. It then runs one variable-latency data-memory transaction and returns aligned, extended load data (or a store completion) to write-back over a valid/ready handshake.

---
 rtl/lsu.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one RV32I data-memory access per request, aligned/extended result to write-back.
// Latency: accept N -> mem_req N+1; out_valid N+3 at best, N+1 for no-access/error, N+1+TIMEOUT_CYCLES on timeout.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready. Optional: LSU_MISALIGN_CHECK_EN.
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [2:0]  in_memop,
   input  logic        in_memwr,
   input  logic        in_memrd,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state, state_nxt;
   logic [15:0] tcnt;
   logic [2:0]  op_q;
   logic [1:0]  lane_q;

   logic        op_skip, op_ill, op_both, op_neither, op_mis;
   logic        dec_none, dec_bad;
   logic [3:0]  st_mask;
   logic [31:0] st_data;
   logic [1:0]  ld_off;
   logic [31:0] ld_sh, ld_val;
   logic        expire, accept, fin_err, fin_zero, fin_load;

   assign expire = (tcnt == 16'(TIMEOUT_CYCLES - 1));

   // Classify the incoming request. A 111 memop wins over any other flag
   // combination; an illegal memop wins over "neither read nor write".
   always_comb begin
      op_skip    = (in_memop == 3'b111);
      op_ill     = (in_memop == 3'b011) || (in_memop == 3'b110);
      op_both    = in_memrd && in_memwr;
      op_neither = !in_memrd && !in_memwr;
`ifdef LSU_MISALIGN_CHECK_EN
      op_mis     = ((in_memop[1:0] == 2'b01) && in_addr[0]) ||
                   ((in_memop[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
`else
      op_mis     = 1'b0;
`endif
      dec_none   = op_skip || (!op_ill && op_neither);
      dec_bad    = op_ill || op_both || op_mis;
   end

   // Store lane placement; halves use addr[1] only so an odd offset never spills out of the word.
   always_comb begin
      st_mask = 4'b1111;
      st_data = in_wdata;
      case (in_memop[1:0])
         2'b00: begin
            st_mask = 4'b0001 << in_addr[1:0];
            st_data = {4{in_wdata[7:0]}};
         end
         2'b01: begin
            st_mask = 4'b0011 << {in_addr[1], 1'b0};
            st_data = {2{in_wdata[15:0]}};
         end
         default: begin
            st_mask = 4'b1111;
            st_data = in_wdata;
         end
      endcase
   end

   // Load lane selection and sign/zero extension of the returned word.
   always_comb begin
      ld_off = 2'b00;
      case (op_q[1:0])
         2'b00:   ld_off = lane_q;
         2'b01:   ld_off = {lane_q[1], 1'b0};
         default: ld_off = 2'b00;
      endcase
      ld_sh = mem_rdata >> {ld_off, 3'b000};
      case (op_q[1:0])
         2'b00:   ld_val = op_q[2] ? {24'b0, ld_sh[7:0]}  : {{24{ld_sh[7]}}, ld_sh[7:0]};
         2'b01:   ld_val = op_q[2] ? {16'b0, ld_sh[15:0]} : {{16{ld_sh[15]}}, ld_sh[15:0]};
         default: ld_val = ld_sh;
      endcase
   end

   // Next-state logic. A grant in the very cycle the timeout expires is still
   // abandoned; a response in that cycle is taken since its data is valid.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      fin_err   = 1'b0;
      fin_zero  = 1'b0;
      fin_load  = 1'b0;
      in_ready  = (state == IDLE);
      mem_req   = (state == REQ);
      out_valid = (state == DONE);
      case (state)
         IDLE: begin
            if (in_valid) begin
               accept = 1'b1;
               if (dec_none) begin
                  state_nxt = DONE;
                  fin_zero  = 1'b1;
               end else if (dec_bad) begin
                  state_nxt = DONE;
                  fin_err   = 1'b1;
               end else begin
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            if (expire) begin
               state_nxt = DONE;
               fin_err   = 1'b1;
            end else if (mem_gnt) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_nxt = DONE;
               fin_load  = 1'b1;
            end else if (expire) begin
               state_nxt = DONE;
               fin_err   = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, request capture, timeout counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tcnt      <= '0;
         op_q      <= '0;
         lane_q    <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         out_rdata <= '0;
         out_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            tcnt      <= '0;
            op_q      <= in_memop;
            lane_q    <= in_addr[1:0];
            mem_we    <= in_memwr;
            mem_addr  <= {in_addr[31:2], 2'b00};
            mem_wdata <= in_memwr ? st_data : 32'h0;
            mem_wmask <= in_memwr ? st_mask : 4'b0000;
         end else if (state == REQ || state == WAIT) begin
            tcnt <= tcnt + 16'd1;
         end
         if (fin_err || fin_zero) begin
            out_rdata <= '0;
            out_err   <= fin_err;
         end else if (fin_load) begin
            out_rdata <= mem_we ? 32'h0 : ld_val;
            out_err   <= 1'b0;
         end else if (state == DONE && out_ready) begin
            out_rdata <= '0;
            out_err   <= 1'b0;
         end
      end
   end

endmodule
